// File: rtl/approx_err_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
// Optional worst-case error tracking is enabled by defining AERR_WCE_EN.
package approx_err_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StDone
    } state_e;

    // Done is raised on the third edge after the final accept.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    function automatic int unsigned SUM_W(input int unsigned w);
        return w + 1;
    endfunction

    function automatic int unsigned SAE_W(input int unsigned w, input int unsigned log_n);
        return w + 1 + log_n;
    endfunction

    function automatic int unsigned SSE_W(input int unsigned w, input int unsigned log_n);
        return 2 * (w + 1) + log_n;
    endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Stage S1: recomputes the exact sum and registers |error| and a nonzero flag
// for each accepted sample.
module approx_err_calc
    import approx_err_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_accept,
    input  logic [W-1:0]        i_a,
    input  logic [W-1:0]        i_b,
    input  logic [SUM_W(W)-1:0] i_s,
    output logic                o_vld,
    output logic                o_nz,
    output logic [SUM_W(W)-1:0] o_abs_e
);

    localparam int unsigned SW = SUM_W(W);

    logic [SW-1:0] w_exact;
    logic [SW:0]   w_err;
    logic [SW:0]   w_mag;

    logic          r_vld;
    logic          r_nz;
    logic [SW-1:0] r_abs_e;

    assign w_exact = {1'b0, i_a} + {1'b0, i_b};
    // One extra bit holds the sign of the two's-complement difference.
    assign w_err   = {1'b0, i_s} - {1'b0, w_exact};
    assign w_mag   = w_err[SW] ? (~w_err + {{SW{1'b0}}, 1'b1}) : w_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= 1'b0;
            r_nz    <= 1'b0;
            r_abs_e <= '0;
        end else begin
            r_vld <= i_accept;
            if (i_accept) begin
                r_nz    <= |w_err;
                r_abs_e <= w_mag[SW-1:0];
            end
        end
    end

    assign o_vld   = r_vld;
    assign o_nz    = r_nz;
    assign o_abs_e = r_abs_e;

endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error-metric engine (error count, SAE, SSE) for an approximate adder.
// Define AERR_WCE_EN to add the worst-case |error| output wce.
module approx_err_monitor
    import approx_err_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned LOG_N = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_a,
    input  logic [W-1:0]               in_b,
    input  logic [SUM_W(W)-1:0]        in_s,
    output logic                       done,
    output logic [LOG_N:0]             err_cnt,
    output logic [SAE_W(W,LOG_N)-1:0]  sae,
    output logic [SSE_W(W,LOG_N)-1:0]  sse
`ifdef AERR_WCE_EN
    ,
    output logic [SUM_W(W)-1:0]        wce
`endif
);

    localparam int unsigned SW = SUM_W(W);
    localparam int unsigned AW = SAE_W(W, LOG_N);
    localparam int unsigned QW = SSE_W(W, LOG_N);
    localparam logic [LOG_N:0] CNT_LAST = {1'b0, {LOG_N{1'b1}}};

    state_e          r_state;
    logic [LOG_N:0]  r_cnt;
    logic [1:0]      r_drain;
    logic            r_in_ready;
    logic            r_done;
    logic [LOG_N:0]  r_err_cnt;
    logic [AW-1:0]   r_sae;
    logic [QW-1:0]   r_sse;

    logic            w_accept;
    logic            w_restart;
    logic            w_s1_vld;
    logic            w_s1_nz;
    logic [SW-1:0]   w_s1_abs;
    logic [2*SW-1:0] w_sq;

    assign w_accept  = in_valid & r_in_ready;
    assign w_restart = start & ((r_state == StIdle) | (r_state == StDone));

    approx_err_calc #(
        .W (W)
    ) u_calc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_accept (w_accept),
        .i_a      (in_a),
        .i_b      (in_b),
        .i_s      (in_s),
        .o_vld    (w_s1_vld),
        .o_nz     (w_s1_nz),
        .o_abs_e  (w_s1_abs)
    );

    assign w_sq = {{SW{1'b0}}, w_s1_abs} * {{SW{1'b0}}, w_s1_abs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_drain    <= '0;
            r_in_ready <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state    <= StAccum;
                        r_cnt      <= '0;
                        r_done     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                StAccum: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + {{LOG_N{1'b0}}, 1'b1};
                        if (r_cnt == CNT_LAST) begin
                            r_in_ready <= 1'b0;
                            r_drain    <= '0;
                            r_state    <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Stage S2: widths guarantee these sums never wrap over a full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
            r_sae     <= '0;
            r_sse     <= '0;
        end else if (w_restart) begin
            r_err_cnt <= '0;
            r_sae     <= '0;
            r_sse     <= '0;
        end else if (w_s1_vld) begin
            r_err_cnt <= r_err_cnt + {{LOG_N{1'b0}}, w_s1_nz};
            r_sae     <= r_sae + {{LOG_N{1'b0}}, w_s1_abs};
            r_sse     <= r_sse + {{LOG_N{1'b0}}, w_sq};
        end
    end

`ifdef AERR_WCE_EN
    logic [SW-1:0] r_wce;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wce <= '0;
        end else if (w_restart) begin
            r_wce <= '0;
        end else if (w_s1_vld && (w_s1_abs > r_wce)) begin
            r_wce <= w_s1_abs;
        end
    end

    assign wce = r_wce;
`endif

    assign in_ready = r_in_ready;
    assign done     = r_done;
    assign err_cnt  = r_err_cnt;
    assign sae      = r_sae;
    assign sse      = r_sse;

endmodule
